// File: rtl/piradip_trigger_sequencer.sv
// Timed-trigger scheduler: walks a {delay, mask, last} table after start and
// pulses each entry's mask onto the trigger lines for one cycle.
module piradip_trigger_sequencer #(
    parameter int N_TRIG  = 32,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [DELAY_W-1:0]       cfg_delay,
    input  logic [N_TRIG-1:0]        cfg_mask,
    input  logic                     cfg_last,
    output logic                     cfg_rej,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop_en,
    output logic [N_TRIG-1:0]        triggers,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] cur_idx
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        FIRE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [N_TRIG-1:0]   mask_q, mask_d;
    logic                last_q, last_d;
    logic [N_TRIG-1:0]   trig_q, trig_d;
    logic                rej_q, rej_d;
    logic                seq_end;

    logic [DELAY_W-1:0]  tbl_delay [DEPTH];
    logic [N_TRIG-1:0]   tbl_mask  [DEPTH];
    logic                tbl_last  [DEPTH];

    // Table storage has no reset; entries are only meaningful once written.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == IDLE)) begin
            tbl_delay[cfg_addr] <= cfg_delay;
            tbl_mask[cfg_addr]  <= cfg_mask;
            tbl_last[cfg_addr]  <= cfg_last;
        end
    end

    // The final table slot ends the sequence even when its last bit is clear.
    assign seq_end = last_q || (idx_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            trig_q  <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            trig_q  <= trig_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        last_d  = last_q;
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end
                end
                LOAD: begin
                    cnt_d   = tbl_delay[idx_q];
                    mask_d  = tbl_mask[idx_q];
                    last_d  = tbl_last[idx_q];
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = FIRE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIRE: begin
                    if (seq_end) begin
                        if (loop_en) begin
                            idx_d   = '0;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Triggers are registered on entry to FIRE so the pulse spans exactly that cycle.
    always_comb begin
        trig_d   = (state_d == FIRE) ? mask_q : '0;
        rej_d    = cfg_we && (state_q != IDLE);
        busy     = (state_q != IDLE);
        done     = (state_q == FIRE) && seq_end && !loop_en && !abort && !rst;
        triggers = trig_q;
        cfg_rej  = rej_q;
        cur_idx  = idx_q;
    end

endmodule

// File: doc/piradip_trigger_sequencer.md
Name: piradip_trigger_sequencer

Overview:
Programmable timed-trigger scheduler that sequences the trigger vector feeding piradip_trigger_unit.
- Holds a small table of {delay, trigger mask, last} entries.
- On start, it walks the table, waits each entry's delay, then pulses that entry's mask onto the trigger lines for one cycle.
- It sits between the AXI-lite register layer (which fills the table and issues start/abort) and the trigger fan-out. Optional looping gives periodic trigger patterns.

Parameters:
- N_TRIG, 32, width of trigger vector.
- DEPTH, 16, number of table entries (power of 2).
- DELAY_W, 24, width of per-entry delay field.
- ADDR_W, $clog2(DEPTH), table index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  table entry index.
- cfg_delay  in  DELAY_W  delay cycles for entry.
- cfg_mask  in  N_TRIG  trigger mask for entry.
- cfg_last  in  1  entry terminates sequence.
- cfg_rej  out  1  one-cycle pulse: write ignored (busy).
- start  in  1  begin sequence (level sampled per cycle).
- abort  in  1  stop sequence immediately.
- loop_en  in  1  restart at entry 0 after last entry.
- triggers  out  N_TRIG  registered one-cycle trigger pulses.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on final FIRE (non-looping).
- cur_idx  out  ADDR_W  entry currently loaded.

Behaviour:
- Reset:
  - state=IDLE; triggers, busy, done, cfg_rej, cur_idx, counter all 0.
  - Table contents are not reset; they are defined only after being written.
- Table write:
  - cfg_we in IDLE writes entry cfg_addr at the edge.
  - cfg_we while busy: entry unchanged, cfg_rej=1 next cycle.
  - cfg_we and start in the same IDLE cycle: the write lands, and the sequence uses the new value.
- FSM states: IDLE, LOAD, WAIT, FIRE.
  - IDLE: start=1 and abort=0 -> LOAD with idx=0. Otherwise stay.
  - LOAD: cnt<=table[idx].delay, mask/last latched -> WAIT.
  - WAIT: cnt==0 -> FIRE; else cnt<=cnt-1.
  - FIRE: triggers=latched mask for exactly this cycle.
    - If last=1 or idx==DEPTH-1:
      - loop_en=1 (sampled this cycle) -> idx=0, LOAD.
      - else done=1 this cycle, then IDLE.
    - Else idx<=idx+1, LOAD.
- Timing:
  - Start sampled at edge E0: first FIRE cycle begins at edge E0+delay0+2.
  - Subsequent FIRE pulses are spaced delay_next+3 cycles apart (FIRE, LOAD, delay+1 WAIT cycles).
  - Delay 0 is legal: minimum spacing 3.
- Mask 0 is legal: FIRE occurs with triggers=0 (pure delay entry).
- abort:
  - Highest priority, any state -> IDLE at next edge.
  - triggers forced 0 from that edge; no done; cur_idx=0.
  - abort in FIRE cycle: that cycle's pulse still appears (already registered), nothing after.
- start while busy is ignored; start held high after done re-launches on the next IDLE cycle.
- idx wraps DEPTH-1 -> sequence end regardless of the last bit; no out-of-range access.
- cur_idx reflects idx; busy is combinational from state.
- rst mid-sequence: same effect as abort, all outputs 0 next cycle.

Test Plan:
- Write entry0={delay=5, mask=0x1, last=1}; pulse start at edge E0 -> triggers=0x00000001 for exactly one cycle starting at E0+7; done high in same cycle; busy falls the following cycle.
- Entries 0..2 = {0, 0x1, 0}, {2, 0x2, 0}, {4, 0x4, 1}; start -> pulses 0x1, 0x2, 0x4 at E0+2, E0+7, E0+14; exactly one done pulse.
- Same table, loop_en=1 -> pattern repeats with a 0x4-to-0x1 spacing of 3 cycles; assert abort during the second WAIT -> triggers stay 0, busy=0 next cycle, no done.
- cfg_we to entry1 while busy -> cfg_rej pulse, and entry1 is unchanged on the next run; cfg_we and start in the same cycle -> new entry0 values used.
- All 16 entries last=0, delay=1, mask=1<<i -> 16 pulses, sequence ends after entry 15, done=1 once, cur_idx cycles 0..15.
- Assert rst during WAIT with delay=100 -> all outputs 0 next cycle; subsequent start behaves as from reset.
